// File: rtl/code_maker.sv
// Codemaker turn controller: picks a maker, shows the turn, collects four letters
// from the maker, then hands the game to the other player with a one-cycle pulse.
module code_maker #(
  parameter int unsigned SHOW_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        codeMaker,
  input  logic        pickPlayerA,
  input  logic        pickPlayerB,
  input  logic [2:0]  SW,
  input  logic        enterA,
  input  logic        enterB,
  input  logic [1:0]  round_counter,
  output logic [11:0] codemaker_code,
  output logic        codeBreaker,
  output logic        player_A,
  output logic        player_B,
  output logic        makerA,
  output logic        makerB,
  output logic [2:0]  letters_count
);

  localparam int unsigned TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, ENTER, HANDOFF} state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] timer;
  logic          maker_b;
  logic          maker_enter;
  logic          start;
  logic          accept;

  assign start       = codeMaker && (round_counter != 2'd3) && (pickPlayerA || pickPlayerB);
  assign maker_enter = maker_b ? enterB : enterA;
  assign accept      = (state == ENTER) && maker_enter && (SW != 3'b000)
                       && (letters_count != 3'd4);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? SHOW : IDLE;
      SHOW:    next_state = (timer == SHOW_LAST) ? ENTER : SHOW;
      ENTER:   next_state = (letters_count == 3'd4) ? HANDOFF : ENTER;
      HANDOFF: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Timer, maker register and the code/letter datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer          <= '0;
      maker_b        <= 1'b0;
      codemaker_code <= '0;
      letters_count  <= '0;
    end else begin
      timer <= (state == SHOW && next_state == SHOW) ? timer + 1'b1 : '0;
      if (state == IDLE && start)
        maker_b <= !pickPlayerA;
      if (state == SHOW && next_state == ENTER) begin
        codemaker_code <= '0;
        letters_count  <= '0;
      end else if (accept) begin
        codemaker_code <= {codemaker_code[8:0], SW};
        letters_count  <= letters_count + 3'd1;
      end
    end
  end

  always_comb begin
    codeBreaker = (state == HANDOFF);
    player_A    = (state == HANDOFF) && maker_b;
    player_B    = (state == HANDOFF) && !maker_b;
    makerA      = (state != IDLE) && !maker_b;
    makerB      = (state != IDLE) && maker_b;
  end

endmodule

// File: tb/tb_code_maker.sv
// Self-checking bench for code_maker: directed turn scenarios plus a randomized
// run compared every cycle against a behavioural turn model.
module tb_code_maker;

  localparam int unsigned SHOW_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        codeMaker = 1'b0;
  logic        pickPlayerA = 1'b0;
  logic        pickPlayerB = 1'b0;
  logic [2:0]  SW = 3'd0;
  logic        enterA = 1'b0;
  logic        enterB = 1'b0;
  logic [1:0]  round_counter = 2'd0;
  logic [11:0] codemaker_code;
  logic        codeBreaker;
  logic        player_A;
  logic        player_B;
  logic        makerA;
  logic        makerB;
  logic [2:0]  letters_count;

  int n_cmp = 0;
  int n_bad = 0;

  code_maker #(.SHOW_CYCLES(SHOW_CYCLES)) dut (
    .clk(clk), .reset(reset), .codeMaker(codeMaker), .pickPlayerA(pickPlayerA),
    .pickPlayerB(pickPlayerB), .SW(SW), .enterA(enterA), .enterB(enterB),
    .round_counter(round_counter), .codemaker_code(codemaker_code),
    .codeBreaker(codeBreaker), .player_A(player_A), .player_B(player_B),
    .makerA(makerA), .makerB(makerB), .letters_count(letters_count)
  );

  always #5 clk = ~clk;

  // Turn model: phase 0 idle, 1 showing, 2 entering, 3 handing off.
  int m_phase = 0;
  int m_shown = 0;
  int m_maker_b = 0;
  int m_code = 0;
  int m_count = 0;

  task automatic tick();
    int ph, sh, mb, cd, ct;
    ph = m_phase; sh = m_shown; mb = m_maker_b; cd = m_code; ct = m_count;
    if (reset) begin
      ph = 0; sh = 0; mb = 0; cd = 0; ct = 0;
    end else begin
      case (m_phase)
        0: if (codeMaker && round_counter != 3 && (pickPlayerA || pickPlayerB)) begin
             ph = 1; sh = 1; mb = pickPlayerA ? 0 : 1;
           end
        1: if (m_shown == SHOW_CYCLES) begin
             ph = 2; cd = 0; ct = 0;
           end else sh = m_shown + 1;
        2: if (m_count == 4) ph = 3;
           else if ((m_maker_b ? enterB : enterA) && SW != 0) begin
             cd = (m_code * 8 + SW) % 4096; ct = m_count + 1;
           end
        default: ph = 0;
      endcase
    end
    @(posedge clk); #1;
    m_phase = ph; m_shown = sh; m_maker_b = mb; m_code = cd; m_count = ct;
  endtask

  task automatic start_turn(input logic pick_a);
    codeMaker = 1'b1; pickPlayerA = pick_a; pickPlayerB = !pick_a;
    tick();
    codeMaker = 1'b0; pickPlayerA = 1'b0; pickPlayerB = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (codemaker_code !== 12'd0) begin n_bad++; $display("FAIL reset_code got %h exp 000", codemaker_code); end
    n_cmp++; if (letters_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", letters_count); end
    n_cmp++; if ({codeBreaker, player_A, player_B, makerA, makerB} !== 5'b0)
      begin n_bad++; $display("FAIL reset_flags got %b exp 00000", {codeBreaker, player_A, player_B, makerA, makerB}); end
    tick();
    n_cmp++; if (makerA !== 1'b0 || makerB !== 1'b0)
      begin n_bad++; $display("FAIL reset_idle got %b%b exp 00", makerA, makerB); end
  endtask

  task automatic test_maker_a();
    round_counter = 2'd0;
    start_turn(1'b1);
    for (int i = 0; i < SHOW_CYCLES; i++) begin
      n_cmp++; if (makerA !== 1'b1 || makerB !== 1'b0 || codeBreaker !== 1'b0)
        begin n_bad++; $display("FAIL a_show%0d got mA=%b mB=%b cb=%b exp 1 0 0", i, makerA, makerB, codeBreaker); end
      if (i < SHOW_CYCLES - 1) tick();
    end
    tick();
    n_cmp++; if (letters_count !== 3'd0 || makerA !== 1'b1)
      begin n_bad++; $display("FAIL a_enter got cnt=%0d mA=%b exp 0 1", letters_count, makerA); end
    for (int s = 1; s <= 4; s++) begin
      enterA = 1'b1; SW = 3'(s);
      tick();
    end
    enterA = 1'b0; SW = 3'd0;
    n_cmp++; if (codemaker_code !== 12'o1234) begin n_bad++; $display("FAIL a_code got %o exp 1234", codemaker_code); end
    n_cmp++; if (letters_count !== 3'd4 || codeBreaker !== 1'b0)
      begin n_bad++; $display("FAIL a_full got cnt=%0d cb=%b exp 4 0", letters_count, codeBreaker); end
    tick();
    n_cmp++; if (codeBreaker !== 1'b1 || player_B !== 1'b1 || player_A !== 1'b0)
      begin n_bad++; $display("FAIL a_handoff got cb=%b pA=%b pB=%b exp 1 0 1", codeBreaker, player_A, player_B); end
    tick();
    n_cmp++; if (codeBreaker !== 1'b0 || makerA !== 1'b0 || player_B !== 1'b0)
      begin n_bad++; $display("FAIL a_idle got cb=%b mA=%b pB=%b exp 0 0 0", codeBreaker, makerA, player_B); end
  endtask

  task automatic test_maker_b();
    start_turn(1'b0);
    n_cmp++; if (makerB !== 1'b1 || makerA !== 1'b0 || codemaker_code !== 12'o1234)
      begin n_bad++; $display("FAIL b_show got mB=%b mA=%b code=%o exp 1 0 1234", makerB, makerA, codemaker_code); end
    repeat (SHOW_CYCLES - 1) tick();
    n_cmp++; if (codemaker_code !== 12'o1234) begin n_bad++; $display("FAIL b_hold got %o exp 1234", codemaker_code); end
    tick();
    n_cmp++; if (codemaker_code !== 12'd0) begin n_bad++; $display("FAIL b_clear got %o exp 0", codemaker_code); end
    enterA = 1'b1; SW = 3'd5;
    tick(); tick();
    enterA = 1'b0; enterB = 1'b1; SW = 3'd0;
    tick();
    n_cmp++; if (letters_count !== 3'd0) begin n_bad++; $display("FAIL b_ignore got %0d exp 0", letters_count); end
    for (int s = 0; s < 4; s++) begin
      SW = (s == 0 || s == 1) ? 3'd5 : 3'(s + 4);
      tick();
    end
    enterB = 1'b0; SW = 3'd0;
    n_cmp++; if (codemaker_code !== 12'o5567) begin n_bad++; $display("FAIL b_code got %o exp 5567", codemaker_code); end
    tick();
    n_cmp++; if (codeBreaker !== 1'b1 || player_A !== 1'b1 || player_B !== 1'b0)
      begin n_bad++; $display("FAIL b_handoff got cb=%b pA=%b pB=%b exp 1 1 0", codeBreaker, player_A, player_B); end
    tick();
  endtask

  task automatic test_priority_gameover();
    codeMaker = 1'b1; pickPlayerA = 1'b1; pickPlayerB = 1'b1;
    tick();
    codeMaker = 1'b0; pickPlayerA = 1'b0; pickPlayerB = 1'b0;
    n_cmp++; if (makerA !== 1'b1 || makerB !== 1'b0)
      begin n_bad++; $display("FAIL prio got mA=%b mB=%b exp 1 0", makerA, makerB); end
    reset = 1'b1; tick(); reset = 1'b0;
    codeMaker = 1'b1; pickPlayerA = 1'b1; round_counter = 2'd3;
    repeat (3) tick();
    n_cmp++; if ({codeBreaker, player_A, player_B, makerA, makerB} !== 5'b0 || letters_count !== 3'd0)
      begin n_bad++; $display("FAIL gameover got flags=%b cnt=%0d exp 00000 0", {codeBreaker, player_A, player_B, makerA, makerB}, letters_count); end
    codeMaker = 1'b0; pickPlayerA = 1'b0; round_counter = 2'd0;
  endtask

  task automatic test_reset_mid_turn();
    int pulses;
    start_turn(1'b1);
    repeat (SHOW_CYCLES) tick();
    enterA = 1'b1; SW = 3'd6;
    tick(); tick();
    enterA = 1'b0;
    n_cmp++; if (letters_count !== 3'd2) begin n_bad++; $display("FAIL mid_two got %0d exp 2", letters_count); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (codemaker_code !== 12'd0 || letters_count !== 3'd0 || makerA !== 1'b0)
      begin n_bad++; $display("FAIL mid_reset got code=%o cnt=%0d mA=%b exp 0 0 0", codemaker_code, letters_count, makerA); end
    pulses = 0;
    repeat (6) begin tick(); if (codeBreaker === 1'b1) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL mid_nopulse got %0d exp 0", pulses); end
  endtask

  task automatic test_back_to_back_enter();
    int pulses;
    start_turn(1'b1);
    repeat (SHOW_CYCLES) tick();
    enterA = 1'b1; SW = 3'd3;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (codeBreaker === 1'b1) pulses++;
      if (i == 4) begin
        n_cmp++; if (codemaker_code !== 12'o3333 || letters_count !== 3'd4)
          begin n_bad++; $display("FAIL hold_code got %o cnt=%0d exp 3333 4", codemaker_code, letters_count); end
      end
    end
    enterA = 1'b0; SW = 3'd0;
    repeat (3) begin tick(); if (codeBreaker === 1'b1) pulses++; end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL hold_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_random();
    logic [11:0] ec;
    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(0, 199) == 0);
      codeMaker = ($urandom_range(0, 9) == 0);
      pickPlayerA = 1'($urandom);
      pickPlayerB = 1'($urandom);
      round_counter = 2'($urandom);
      SW = 3'($urandom);
      enterA = 1'($urandom);
      enterB = 1'($urandom);
      tick();
      ec = 12'(m_code);
      n_cmp++; if (codemaker_code !== ec) begin n_bad++; $display("FAIL rand_code t=%0d got %o exp %o", t, codemaker_code, ec); end
      n_cmp++; if (letters_count !== 3'(m_count)) begin n_bad++; $display("FAIL rand_count t=%0d got %0d exp %0d", t, letters_count, m_count); end
      n_cmp++; if (codeBreaker !== (m_phase == 3)) begin n_bad++; $display("FAIL rand_cb t=%0d got %b exp %b", t, codeBreaker, m_phase == 3); end
      n_cmp++; if (player_A !== (m_phase == 3 && m_maker_b == 1)) begin n_bad++; $display("FAIL rand_pA t=%0d got %b", t, player_A); end
      n_cmp++; if (player_B !== (m_phase == 3 && m_maker_b == 0)) begin n_bad++; $display("FAIL rand_pB t=%0d got %b", t, player_B); end
      n_cmp++; if (makerA !== (m_phase != 0 && m_maker_b == 0)) begin n_bad++; $display("FAIL rand_mA t=%0d got %b", t, makerA); end
      n_cmp++; if (makerB !== (m_phase != 0 && m_maker_b == 1)) begin n_bad++; $display("FAIL rand_mB t=%0d got %b", t, makerB); end
    end
    reset = 1'b0; codeMaker = 1'b0; enterA = 1'b0; enterB = 1'b0;
  endtask

  initial begin
    test_reset();
    test_maker_a();
    test_maker_b();
    test_priority_gameover();
    test_reset_mid_turn();
    test_back_to_back_enter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_maker.md
CODE_MAKER -- requirements
Module: code_maker

Interface
REQ-001 Parameter: SHOW_CYCLES, default 4, number of cycles the SHOW state lasts.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 codeMaker  input  1  level; requests a new codemaker turn.
REQ-006 pickPlayerA  input  1  with codeMaker, player A becomes codemaker.
REQ-007 pickPlayerB  input  1  with codeMaker, player B becomes codemaker.
REQ-008 SW  input  3  letter switches; 3'b000 is '-', never accepted.
REQ-009 enterA  input  1  player A enter pulse.
REQ-010 enterB  input  1  player B enter pulse.
REQ-011 round_counter  input  2  completed rounds; 2'd3 means game over.
REQ-012 codemaker_code  output  12  secret code, first letter in [11:9].
REQ-013 codeBreaker  output  1  one-cycle start pulse to the code breaker.
REQ-014 player_A  output  1  codebreaker is A; valid with codeBreaker.
REQ-015 player_B  output  1  codebreaker is B; valid with codeBreaker.
REQ-016 makerA  output  1  A is the active codemaker (SHOW/ENTER/HANDOFF).
REQ-017 makerB  output  1  B is the active codemaker (SHOW/ENTER/HANDOFF).
REQ-018 letters_count  output  3  letters accepted this turn, 0..4.

Function
REQ-019 States SHALL be IDLE, SHOW, ENTER, HANDOFF; a maker register (A/B) SHALL be loaded on leaving IDLE.
REQ-020 IDLE -> SHOW when codeMaker=1, round_counter!=3, and pickPlayerA or pickPlayerB is 1; A has priority if both are set; otherwise the block SHALL stay in IDLE.
REQ-021 SHOW SHALL last exactly SHOW_CYCLES cycles, timed by an internal counter cleared outside SHOW, then go to ENTER; codeMaker is ignored in SHOW.
REQ-022 On the SHOW->ENTER transition, codemaker_code and letters_count SHALL be cleared to 0.
REQ-023 In ENTER, a letter SHALL be accepted in any cycle where the maker's enter input is 1 and SW!=3'b000: codemaker_code <= {codemaker_code[8:0], SW}, letters_count +1.
REQ-024 The enter input of the non-maker player SHALL be ignored, and SW=3'b000 SHALL be ignored.
REQ-025 After the 4th letter is accepted, ENTER -> HANDOFF on the next edge; at most one letter SHALL be accepted per cycle and letters_count SHALL never exceed 4.
REQ-026 HANDOFF SHALL last one cycle with codeBreaker=1, the breaker flag set for the non-maker player (maker A -> player_B=1, maker B -> player_A=1), then go to IDLE.
REQ-027 codeBreaker, player_A and player_B SHALL be 0 outside HANDOFF.
REQ-028 codemaker_code SHALL hold its value in IDLE and SHOW until the next SHOW->ENTER transition.
REQ-029 makerA/makerB SHALL reflect the maker register in SHOW, ENTER and HANDOFF, and be 0 in IDLE.
REQ-030 If codeMaker is still high when the block returns to IDLE, a new turn SHALL start (designers keep codeMaker low at handoff).
REQ-031 An undefined state encoding SHALL go to IDLE next cycle.

Reset
REQ-032 reset=1 at a clock edge SHALL force IDLE, clear the timer, maker register, codemaker_code=0, letters_count=0, and all 1-bit outputs=0, overriding any in-progress turn.
REQ-033 After reset deasserts, the block SHALL accept a new turn only per REQ-020.

Verification
REQ-034 codeMaker=1, pickPlayerA=1, round_counter=0 -> makerA=1 for 4 SHOW cycles; then enterA with SW=1,2,3,4 -> codemaker_code=12'o1234, then a one-cycle codeBreaker=1 with player_B=1, then IDLE.
REQ-035 In ENTER as maker B: enterA pulses and enterB with SW=0 -> letters_count stays 0; enterB with SW=5,5,6,7 -> 12'o5567, player_A=1 at handoff.
REQ-036 codeMaker=1 with both picks set -> makerA=1; codeMaker=1 with round_counter=3 -> stays IDLE, all outputs 0.
REQ-037 Reset asserted after 2 letters -> next cycle IDLE, codemaker_code=0, letters_count=0, no codeBreaker pulse.
REQ-038 enterA held high for 6 cycles with SW=3 -> exactly 4 letters accepted (12'o3333), one handoff pulse.
REQ-039 Return to IDLE, then codeMaker=1/pickPlayerB=1 -> previous code held through SHOW, cleared on entering ENTER.
